int_mul: RTL and testbench
==========================

Name: int_mul

Overview:
Multi-cycle radix-2 shift-add integer multiplier. It is the inverse-operation companion to the integer divider in the ALU and serves the RV32M MUL/MULH/MULHSU/MULHU instructions. It uses the same i_valid/o_valid start/done handshake and IDLE/CALC/DONE control structure as the divider. It returns the full 2*WIDTH-bit product; the ALU selects the low or high half.

Parameters:
WIDTH, 32, operand width in bits; CALC lasts exactly WIDTH cycles.

Ports:
i_clk  input  1  clock; all state updates on the rising edge.
i_rst_n  input  1  synchronous active-low reset, sampled on the rising edge of i_clk.
i_valid  input  1  start pulse; operands and mode are captured on the edge where i_valid=1.
o_valid  output  1  high for exactly one cycle when a product is available.
i_mode  input  2  00 unsigned x unsigned; 01 signed x signed; 10 i_a signed x i_b unsigned; 11 reserved, treated as 00.
i_a  input  WIDTH  multiplicand (rs1).
i_b  input  WIDTH  multiplier (rs2).
o_product  output  2*WIDTH  product. Holds the last completed result until the next completion.

Behaviour:
- Reset (i_rst_n=0 at a rising edge):
  - state=IDLE, counter=0, internal registers=0.
  - o_valid=0, o_product=0.
  - Reset takes priority over i_valid.
- States:
  - IDLE: i_valid -> CALC, else stay.
  - CALC: counter increments each cycle; at counter==WIDTH-1 -> DONE. i_valid during CALC aborts the operation and restarts it with the new operands (counter=0, stay in CALC).
  - DONE: o_valid=1. i_valid -> CALC (back-to-back issue), else -> IDLE.
- Operand capture:
  - On the i_valid edge, register the magnitudes |a| and |b| as WIDTH-bit unsigned values, plus result sign neg.
  - |x| = two's complement of x when x is treated as signed and x[WIDTH-1]=1, else x.
  - The most-negative value 2^(WIDTH-1) is represented exactly as an unsigned magnitude.
  - neg = (a signed & a[MSB]) XOR (b signed & b[MSB]).
  - Inputs need not be held after the capture edge.
- Datapath: one accumulator of 2*WIDTH bits, a shifting multiplier register, and an adder of WIDTH+1 bits.
  - Each CALC cycle: if the multiplier LSB is 1, add |a| into the upper half of the accumulator with carry.
  - Then shift accumulator (including carry) and multiplier right by 1.
- Completion: on the last CALC cycle, o_product is loaded with acc if neg=0, else with the 2*WIDTH-bit two's complement of acc. It is visible in the same cycle o_valid=1.
- Latency: i_valid sampled at edge E0 -> o_valid=1 in the cycle following edge E0+WIDTH (33 edges for WIDTH=32).
- Throughput: one result per WIDTH+1 cycles with back-to-back i_valid asserted in DONE.
- o_product changes only at completion; it is never updated on abort or while in IDLE.
- No exceptions: zero operands and extreme values are computed normally.

Test Plan:
1. Reset, then mode 01, a=7, b=-3 (0xFFFFFFFD) -> o_valid high exactly 33 edges after the i_valid edge, one cycle wide; o_product=0xFFFFFFFF_FFFFFFEB.
2. Mode 01, a=b=0x80000000 -> o_product=0x40000000_00000000. Mode 00, a=b=0xFFFFFFFF -> 0xFFFFFFFE_00000001.
3. Mode 10, a=0xFFFFFFFF (-1), b=0xFFFFFFFF (unsigned) -> 0xFFFFFFFF_00000001. Mode 11 with the same operands -> 0xFFFFFFFE_00000001.
4. Back-to-back: i_valid in DONE with a=0, b=12345 -> first o_valid pulse is followed 33 cycles later by a second; product=0. o_product holds the first result in between.
5. Abort: i_valid (a=3, b=5) then, 10 cycles into CALC, i_valid (a=6, b=7, mode 00) -> single o_valid 33 edges after the second i_valid; o_product=42.
6. Reset mid-CALC: assert i_rst_n=0 for one edge -> o_valid=0, o_product=0, state IDLE; no o_valid afterwards without a new i_valid.

Source files
------------

// File: rtl/int_mul.sv
// int_mul: multi-cycle radix-2 shift-add integer multiplier for RV32M
// MUL/MULH/MULHSU/MULHU. It returns the full 2*WIDTH-bit product and the
// ALU picks the low or high half. The handshake and IDLE/CALC/DONE control
// match the integer divider: one start pulse in, one done pulse out.
module int_mul #(
    parameter int WIDTH = 32
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_valid,
    input  logic [1:0]           i_mode,
    input  logic [WIDTH-1:0]     i_a,
    input  logic [WIDTH-1:0]     i_b,
    output logic                 o_valid,
    output logic [2*WIDTH-1:0]   o_product
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CALC = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic [CNT_W-1:0]   CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0]   CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(WIDTH - 1);
    localparam logic [WIDTH-1:0]   ONE_W    = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [2*WIDTH-1:0] ONE_2W   = {{(2*WIDTH-1){1'b0}}, 1'b1};

    // Unsigned magnitude of an operand. The most-negative value maps onto
    // 2^(WIDTH-1), which fits because the result is read as unsigned.
    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] x,
                                                   input logic             is_signed);
        logic [WIDTH-1:0] r;
        if (is_signed && x[WIDTH-1]) begin
            r = ~x + ONE_W;
        end else begin
            r = x;
        end
        return r;
    endfunction

    logic [1:0]         state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   mplr_q, mplr_d;
    logic [WIDTH-1:0]   amag_q, amag_d;
    logic               neg_q, neg_d;
    logic [2*WIDTH-1:0] prod_q, prod_d;
    logic               valid_q, valid_d;

    logic               a_signed_s;
    logic               b_signed_s;
    logic [WIDTH:0]     sum_s;
    logic [2*WIDTH-1:0] acc_step_s;

    // Operand signedness per mode; the reserved mode behaves as unsigned.
    always_comb begin
        a_signed_s = 1'b0;
        b_signed_s = 1'b0;
        case (i_mode)
            2'b01: begin
                a_signed_s = 1'b1;
                b_signed_s = 1'b1;
            end
            2'b10: begin
                a_signed_s = 1'b1;
                b_signed_s = 1'b0;
            end
            default: begin
                a_signed_s = 1'b0;
                b_signed_s = 1'b0;
            end
        endcase
    end

    // One shift-add step: conditionally add |a| into the upper half with
    // carry, then shift the whole accumulator (carry included) right by one.
    always_comb begin
        if (mplr_q[0]) begin
            sum_s = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, amag_q};
        end else begin
            sum_s = {1'b0, acc_q[2*WIDTH-1:WIDTH]};
        end
        acc_step_s = {sum_s, acc_q[WIDTH-1:1]};
    end

    // Control and datapath next state; a start pulse always (re)captures.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        mplr_d  = mplr_q;
        amag_d  = amag_q;
        neg_d   = neg_q;
        prod_d  = prod_q;
        valid_d = 1'b0;
        if (i_valid) begin
            state_d = ST_CALC;
            cnt_d   = CNT_ZERO;
            acc_d   = {(2*WIDTH){1'b0}};
            amag_d  = magnitude(i_a, a_signed_s);
            mplr_d  = magnitude(i_b, b_signed_s);
            neg_d   = (a_signed_s & i_a[WIDTH-1]) ^ (b_signed_s & i_b[WIDTH-1]);
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d = ST_IDLE;
                end
                ST_CALC: begin
                    acc_d  = acc_step_s;
                    mplr_d = mplr_q >> 1;
                    if (cnt_q == CNT_LAST) begin
                        state_d = ST_DONE;
                        cnt_d   = CNT_ZERO;
                        valid_d = 1'b1;
                        if (neg_q) begin
                            prod_d = ~acc_step_s + ONE_2W;
                        end else begin
                            prod_d = acc_step_s;
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
                ST_DONE: begin
                    state_d = ST_IDLE;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // State registers with synchronous active-low reset taking priority.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= CNT_ZERO;
            acc_q   <= {(2*WIDTH){1'b0}};
            mplr_q  <= {WIDTH{1'b0}};
            amag_q  <= {WIDTH{1'b0}};
            neg_q   <= 1'b0;
            prod_q  <= {(2*WIDTH){1'b0}};
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            mplr_q  <= mplr_d;
            amag_q  <= amag_d;
            neg_q   <= neg_d;
            prod_q  <= prod_d;
            valid_q <= valid_d;
        end
    end

    assign o_valid   = valid_q;
    assign o_product = prod_q;

endmodule

// File: tb/tb_int_mul.sv
// Self-checking bench for int_mul: directed scenarios followed by random
// operations compared against a plain-arithmetic product model.
module tb_int_mul;

    localparam int W = 32;

    logic          i_clk;
    logic          i_rst_n;
    logic          i_valid;
    logic [1:0]    i_mode;
    logic [W-1:0]  i_a;
    logic [W-1:0]  i_b;
    logic          o_valid;
    logic [2*W-1:0] o_product;

    int vectors;
    int miscompares;

    int_mul #(.WIDTH(W)) dut (
        .i_clk     (i_clk),
        .i_rst_n   (i_rst_n),
        .i_valid   (i_valid),
        .i_mode    (i_mode),
        .i_a       (i_a),
        .i_b       (i_b),
        .o_valid   (o_valid),
        .o_product (o_product)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    // Reference: extend each operand to 64 bits per its signedness and
    // multiply; the low 64 bits of that product are the exact result.
    function automatic logic [63:0] ref_mul(input logic [31:0] a,
                                            input logic [31:0] b,
                                            input logic [1:0]  mode);
        logic [63:0] ea;
        logic [63:0] eb;
        ea = {32'd0, a};
        eb = {32'd0, b};
        if (mode == 2'b01 || mode == 2'b10) ea = {{32{a[31]}}, a};
        if (mode == 2'b01)                  eb = {{32{b[31]}}, b};
        return ea * eb;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed=0x%016h expected=0x%016h", tag, obs, exp);
        end
    endtask

    // Present a start pulse for one edge, then scramble the inputs.
    task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic [1:0] mode);
        i_valid = 1'b1;
        i_a     = a;
        i_b     = b;
        i_mode  = mode;
        @(negedge i_clk);
        i_valid = 1'b0;
        i_a     = $urandom;
        i_b     = $urandom;
        i_mode  = 2'($urandom_range(3, 0));
    endtask

    // Wait (bounded) for o_valid; check latency, product and optionally that
    // o_product held a given value while waiting.
    task automatic wait_done(input string tag, input logic [63:0] exp,
                             input bit hold_chk, input logic [63:0] hold_val);
        int n;
        bit held_ok;
        n = 0;
        held_ok = 1'b1;
        while (o_valid !== 1'b1 && n < 100) begin
            if (hold_chk && o_product !== hold_val) held_ok = 1'b0;
            @(negedge i_clk);
            n++;
        end
        chk({tag, "_latency"}, 64'(n), 64'(W));
        chk({tag, "_product"}, o_product, exp);
        if (hold_chk) chk({tag, "_hold"}, {63'd0, held_ok}, 64'd1);
    endtask

    task automatic op_check(input string tag, input logic [31:0] a, input logic [31:0] b,
                            input logic [1:0] mode, input logic [63:0] exp);
        issue(a, b, mode);
        wait_done(tag, exp, 1'b0, 64'd0);
        @(negedge i_clk);
        chk({tag, "_pulse_width"}, {63'd0, o_valid}, 64'd0);
    endtask

    initial begin
        logic [63:0] first;
        logic [31:0] ra;
        logic [31:0] rb;
        logic [1:0]  rm;
        bit          quiet;

        vectors     = 0;
        miscompares = 0;
        i_rst_n = 1'b0;
        i_valid = 1'b1;
        i_mode  = 2'b01;
        i_a     = 32'd9;
        i_b     = 32'd9;
        repeat (3) @(negedge i_clk);
        chk("reset_valid", {63'd0, o_valid}, 64'd0);
        chk("reset_product", o_product, 64'd0);
        i_valid = 1'b0;
        i_rst_n = 1'b1;
        @(negedge i_clk);
        chk("idle_valid", {63'd0, o_valid}, 64'd0);

        // Signed small values and extremes.
        op_check("s7xm3", 32'd7, 32'hFFFF_FFFD, 2'b01, 64'hFFFF_FFFF_FFFF_FFEB);
        op_check("s_minsq", 32'h8000_0000, 32'h8000_0000, 2'b01, 64'h4000_0000_0000_0000);
        op_check("u_maxsq", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 2'b00, 64'hFFFF_FFFE_0000_0001);
        op_check("su_m1xmax", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 2'b10, 64'hFFFF_FFFF_0000_0001);
        op_check("rsvd_maxsq", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 2'b11, 64'hFFFF_FFFE_0000_0001);

        // Back-to-back: second start issued in the DONE cycle.
        issue(32'd1234, 32'd1000, 2'b00);
        wait_done("b2b_first", 64'd1234000, 1'b0, 64'd0);
        first = o_product;
        issue(32'd0, 32'd12345, 2'b01);
        wait_done("b2b_second", 64'd0, 1'b1, 64'd1234000);
        @(negedge i_clk);
        chk("b2b_pulse_width", {63'd0, o_valid}, 64'd0);

        // Abort: restart ten cycles into CALC; only one completion expected.
        issue(32'd3, 32'd5, 2'b00);
        quiet = 1'b1;
        repeat (9) begin
            if (o_valid !== 1'b0) quiet = 1'b0;
            @(negedge i_clk);
        end
        issue(32'd6, 32'd7, 2'b00);
        if (o_valid !== 1'b0) quiet = 1'b0;
        chk("abort_no_early_valid", {63'd0, quiet}, 64'd1);
        wait_done("abort", 64'd42, 1'b1, 64'd0);
        quiet = 1'b1;
        repeat (40) begin
            @(negedge i_clk);
            if (o_valid !== 1'b0) quiet = 1'b0;
        end
        chk("abort_single_pulse", {63'd0, quiet}, 64'd1);

        // Reset in the middle of CALC.
        issue(32'd100, 32'd200, 2'b00);
        repeat (10) @(negedge i_clk);
        i_rst_n = 1'b0;
        @(negedge i_clk);
        i_rst_n = 1'b1;
        chk("midrst_valid", {63'd0, o_valid}, 64'd0);
        chk("midrst_product", o_product, 64'd0);
        quiet = 1'b1;
        repeat (45) begin
            @(negedge i_clk);
            if (o_valid !== 1'b0 || o_product !== 64'd0) quiet = 1'b0;
        end
        chk("midrst_quiet", {63'd0, quiet}, 64'd1);

        // Randomized operations against the model.
        for (int k = 0; k < 24; k++) begin
            ra = $urandom;
            rb = $urandom;
            rm = 2'($urandom_range(3, 0));
            if (k % 6 == 1) ra = 32'h8000_0000;
            if (k % 6 == 2) rb = 32'h0000_0000;
            if (k % 6 == 3) rb = 32'hFFFF_FFFF;
            op_check($sformatf("rand%0d_m%0d", k, rm), ra, rb, rm, ref_mul(ra, rb, rm));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
